// File: rtl/playground_out_arbiter_if.sv
// Shared output-bus bundle between the demo sub-blocks and the output arbiter.
// master: requester side (drives requests and data, observes grant/output).
// slave:  arbiter side (observes requests and data, drives grant/output).
interface playground_out_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   grant;
  logic [1:0]         owner;
  logic [7:0]         out_data;
  logic               out_valid;

  modport master (
    output req, req_data,
    input  grant, owner, out_data, out_valid
  );

  modport slave (
    input  req, req_data,
    output grant, owner, out_data, out_valid
  );
endinterface

// File: rtl/playground_out_arbiter.sv
// Round-robin arbiter sharing the 8-bit uo_out bus between up to four demo
// sub-blocks. Each owner holds the bus for a bounded time slice (unless
// locked), and a blanking gap separates consecutive owners.
module playground_out_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned SLICE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    lock,
  playground_out_arbiter_if.slave bus
);

  localparam int unsigned SLICE_W = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;
  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SLICE_W-1:0] SLICE_MAX = SLICE_W'(SLICE_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_MAX   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [N_REQ-1:0]   GRANT_ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_t;

  state_t             state;
  logic [N_REQ-1:0]   grant_q;
  logic [1:0]         owner_q;
  logic [1:0]         last_q;
  logic [7:0]         data_q;
  logic               valid_q;
  logic [SLICE_W-1:0] slice_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic       sel_found;
  logic [1:0] sel_idx;
  logic [1:0] cand;
  logic [7:0] owner_data;
  logic       owner_req;
  logic       others_req;
  logic       slice_exp;

  // Round-robin search starting just after the last owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last_q;
    cand      = last_q;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = 2'((32'(last_q) + off) % N_REQ);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Current owner's data and release conditions.
  always_comb begin
    owner_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == 2'(i)) begin
        owner_data = bus.req_data[8*i +: 8];
      end
    end
    owner_req  = bus.req[owner_q];
    others_req = |(bus.req & ~grant_q);
    slice_exp  = (slice_cnt == SLICE_MAX);
  end

  // Arbitration FSM with registered grant, owner and output data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= 2'(N_REQ - 1);
      data_q    <= '0;
      valid_q   <= 1'b0;
      slice_cnt <= '0;
      gap_cnt   <= '0;
    end else if (!ena) begin
      state     <= IDLE;
      grant_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      slice_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          grant_q <= '0;
          valid_q <= 1'b0;
          gap_cnt <= '0;
          if (sel_found) begin
            grant_q   <= GRANT_ONE << sel_idx;
            owner_q   <= sel_idx;
            last_q    <= sel_idx;
            slice_cnt <= '0;
            state     <= OWN;
          end
        end
        OWN: begin
          // The release edge still forwards data, so valid lasts a full slice.
          data_q  <= owner_data;
          valid_q <= 1'b1;
          if (!owner_req || (slice_exp && !lock && others_req)) begin
            grant_q   <= '0;
            slice_cnt <= '0;
            gap_cnt   <= '0;
            state     <= GAP;
          end else if (slice_exp) begin
            if (!lock) begin
              slice_cnt <= '0;
            end
          end else begin
            slice_cnt <= slice_cnt + 1'b1;
          end
        end
        GAP: begin
          grant_q <= '0;
          valid_q <= 1'b0;
          if (gap_cnt == GAP_MAX) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          grant_q <= '0;
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_playground_out_arbiter.sv
// Scoreboard bench for playground_out_arbiter: each stimulus step queues the
// expected (cycle, owner, data) of every valid output beat; a monitor pops
// and compares whenever out_valid is high. Direct checks cover grant timing,
// gaps, ena and asynchronous reset.
module tb_playground_out_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena   = 1'b0;
  logic        lock  = 1'b0;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  owner;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  playground_out_arbiter_if #(.N_REQ(4)) bus ();

  playground_out_arbiter #(
    .N_REQ(4),
    .SLICE_CYCLES(16),
    .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .lock(lock),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_run(input logic [1:0] o, input logic [7:0] d,
                          input int unsigned start, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      sb.push_back('{cyc: start + i, owner: o, data: d});
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({bus.grant, bus.owner, bus.out_data, bus.out_valid});
  endfunction

  // Monitor: every valid beat must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("sb_owner", 32'(bus.owner), 32'(mon_e.owner));
          chk("sb_data", 32'(bus.out_data), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    int unsigned c;
    logic [7:0] rr_data [4];
    rr_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.req      = '0;
    bus.req_data = 32'h4433_2211;
    ena          = 1'b1;

    // Reset and idle
    step(3);
    chk("reset_outputs", all_out(), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_outputs", all_out(), 32'd0);
    end

    // Single requester, holds past the slice with no competitor
    bus.req_data = 32'h4433_22A5;
    c = cyc;
    bus.req = 4'b0001;
    push_run(2'd0, 8'hA5, c + 2, 21);
    step(1);
    chk("single_grant", 32'(bus.grant), 32'h1);
    step(20);
    chk("single_hold_grant", 32'(bus.grant), 32'h1);
    bus.req = '0;
    step(12);
    chk("single_drain", 32'(sb.size()), 32'd0);
    chk("single_release", 32'({bus.grant, bus.out_valid}), 32'd0);

    // Round-robin with slices, starting from a fresh pointer
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    bus.req_data = 32'h4433_2211;
    c = cyc;
    bus.req = 4'b1111;
    for (int unsigned k = 0; k < 4; k++) begin
      push_run(2'(k), rr_data[k], c + 2 + 19 * k, 16);
    end
    push_run(2'd0, 8'h11, c + 78, 4);
    for (int t = 1; t <= 80; t++) begin
      step(1);
      if (t >= 18 && t <= 20) begin
        chk("rr_gap_valid", 32'(bus.out_valid), 32'd0);
        chk("rr_gap_hold", 32'(bus.out_data), 32'h11);
      end
      if (t == 19) chk("rr_gap_grant", 32'(bus.grant), 32'h0);
      if (t == 20) chk("rr_next_grant", 32'(bus.grant), 32'h2);
    end
    bus.req = '0;
    step(12);
    chk("rr_drain", 32'(sb.size()), 32'd0);

    // Lock keeps owner 1 past the slice; dropping req still releases
    c = cyc;
    lock = 1'b1;
    bus.req = 4'b0011;
    push_run(2'd1, 8'h22, c + 2, 30);
    push_run(2'd0, 8'h11, c + 35, 7);
    step(30);
    chk("lock_hold_grant", 32'(bus.grant), 32'h2);
    bus.req = 4'b0001;
    step(3);
    chk("lock_gap_grant", 32'(bus.grant), 32'h0);
    step(1);
    chk("lock_next_grant", 32'(bus.grant), 32'h1);
    step(6);
    bus.req = '0;
    lock = 1'b0;
    step(12);
    chk("lock_drain", 32'(sb.size()), 32'd0);

    // Early release by owner 2, then round-robin resumes after owner 0
    c = cyc;
    bus.req = 4'b0101;
    push_run(2'd2, 8'h33, c + 2, 5);
    push_run(2'd0, 8'h11, c + 10, 4);
    push_run(2'd1, 8'h22, c + 17, 5);
    step(1);
    chk("early_grant", 32'(bus.grant), 32'h4);
    step(4);
    bus.req = 4'b0001;
    step(1);
    chk("early_release_grant", 32'(bus.grant), 32'h0);
    chk("early_release_valid", 32'(bus.out_valid), 32'd1);
    step(3);
    chk("early_next_grant", 32'(bus.grant), 32'h1);
    step(3);
    bus.req = 4'b0110;
    step(4);
    chk("early_rr_grant", 32'(bus.grant), 32'h2);
    step(4);
    bus.req = '0;
    step(12);
    chk("early_drain", 32'(sb.size()), 32'd0);

    // ena drop mid-OWN, pointer preserved, then asynchronous reset
    c = cyc;
    bus.req = 4'b0100;
    push_run(2'd2, 8'h33, c + 2, 5);
    push_run(2'd3, 8'h44, c + 12, 3);
    step(6);
    ena = 1'b0;
    step(1);
    chk("ena_grant", 32'(bus.grant), 32'h0);
    chk("ena_valid", 32'(bus.out_valid), 32'd0);
    chk("ena_data", 32'(bus.out_data), 32'h0);
    step(1);
    bus.req = 4'b1111;
    step(2);
    ena = 1'b1;
    step(1);
    chk("ena_restore_grant", 32'(bus.grant), 32'h8);
    chk("ena_restore_owner", 32'(bus.owner), 32'd3);
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_out(), 32'd0);
    step(2);
    bus.req = '0;
    rst_n = 1'b1;
    step(5);
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
